// File: rtl/reg_writeback_if.sv
// ---------------------------------------------------------------------------
// reg_writeback_if
// Valid/ready result channel from one producer (ALU or LSU) into the
// register-file write-back front end.
//   valid : producer holds a result
//   ready : write-back accepts the result on this edge
//   addr  : destination register
//   data  : result value
// The master modport is the producer side; the slave modport is reg_writeback.
// ---------------------------------------------------------------------------
interface reg_writeback_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  valid;
    logic                  ready;
    logic [ADDR_WIDTH-1:0] addr;
    logic [WIDTH-1:0]      data;

    modport master (output valid, output addr, output data, input ready);
    modport slave  (input valid, input addr, input data, output ready);
endinterface

// File: rtl/reg_writeback.sv
// ---------------------------------------------------------------------------
// reg_writeback
// Write-side front end of the integer register file. Two producers (ALU, LSU)
// are arbitrated round-robin into a small FIFO that drains one write per
// cycle to the register file write port. A per-register busy scoreboard lets
// issue logic stall on pending writes.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   alu, lsu          producer channels (reg_writeback_if.slave)
//   wb_stall          freezes the drain side
//   wen/addrw/dinw    register file write port, driven from the FIFO head
//   rsv_en/rsv_addr   issue reserves a destination register
//   busy              scoreboard, bit i = write to register i pending
//   level             FIFO occupancy
//   q_addr/q_hit/q_data  bypass lookup into the FIFO
//
// Optional feature: define REG_WRITEBACK_BYPASS_EN to build the bypass lookup;
// otherwise q_hit and q_data are tied to zero.
// ---------------------------------------------------------------------------
module reg_writeback #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NR_REGS    = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    reg_writeback_if.slave            alu,
    reg_writeback_if.slave            lsu,
    input  logic                      wb_stall,
    output logic                      wen,
    output logic [ADDR_WIDTH-1:0]     addrw,
    output logic [WIDTH-1:0]          dinw,
    input  logic                      rsv_en,
    input  logic [ADDR_WIDTH-1:0]     rsv_addr,
    output logic [NR_REGS-1:0]        busy,
    output logic [$clog2(DEPTH):0]    level,
    input  logic [ADDR_WIDTH-1:0]     q_addr,
    output logic                      q_hit,
    output logic [WIDTH-1:0]          q_data
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q [DEPTH];
    logic [ADDR_WIDTH-1:0] mem_addr_d [DEPTH];
    logic [WIDTH-1:0]      mem_data_q [DEPTH];
    logic [WIDTH-1:0]      mem_data_d [DEPTH];
    logic [NR_REGS-1:0]    busy_q, busy_d;
    logic                  prefer_lsu_q, prefer_lsu_d;

    logic                  full;
    logic                  empty;
    logic                  grant_alu;
    logic                  grant_lsu;
    logic                  accept;
    logic                  push;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [WIDTH-1:0]      acc_data;

    // Extra wrap bit on the pointers separates full from empty.
    assign level = wptr_q - rptr_q;
    assign empty = (wptr_q == rptr_q);
    assign full  = (level == PTR_W'(DEPTH));

    // A lone valid source always wins; on contention the pointer decides.
    assign grant_alu = alu.valid && (!lsu.valid || !prefer_lsu_q);
    assign grant_lsu = lsu.valid && (!alu.valid || prefer_lsu_q);

    // No pass-through when full, even if the head pops this cycle.
    assign alu.ready = grant_alu && !full;
    assign lsu.ready = grant_lsu && !full;

    assign accept   = alu.ready || lsu.ready;
    assign acc_addr = lsu.ready ? lsu.addr : alu.addr;
    assign acc_data = lsu.ready ? lsu.data : alu.data;
    // Writes to x0 complete the handshake but are dropped here.
    assign push     = accept && (acc_addr != '0);

    assign wen   = !empty && !wb_stall;
    assign addrw = mem_addr_q[rptr_q[IDX_W-1:0]];
    assign dinw  = mem_data_q[rptr_q[IDX_W-1:0]];
    assign busy  = busy_q;

    always_comb begin
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        busy_d       = busy_q;
        prefer_lsu_d = prefer_lsu_q;

        if (accept) begin
            prefer_lsu_d = grant_alu;
        end

        if (push) begin
            mem_addr_d[wptr_q[IDX_W-1:0]] = acc_addr;
            mem_data_d[wptr_q[IDX_W-1:0]] = acc_data;
            wptr_d = wptr_q + PTR_W'(1);
        end

        if (wen) begin
            rptr_d        = rptr_q + PTR_W'(1);
            busy_d[addrw] = 1'b0;
        end

        // Applied after the commit clear so a same-cycle reserve wins.
        if (rsv_en && (rsv_addr != '0)) begin
            busy_d[rsv_addr] = 1'b1;
        end

        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            busy_q       <= '0;
            prefer_lsu_q <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_data_q[i] <= '0;
            end
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            busy_q       <= busy_d;
            prefer_lsu_q <= prefer_lsu_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
        end
    end

`ifdef REG_WRITEBACK_BYPASS_EN
    logic [IDX_W-1:0] bp_idx;

    // Scan oldest to youngest so the youngest match ends up in q_data.
    // The head counts as valid even while it pops this cycle.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        bp_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            bp_idx = rptr_q[IDX_W-1:0] + IDX_W'(i);
            if ((PTR_W'(i) < level) && (q_addr != '0) &&
                (mem_addr_q[bp_idx] == q_addr)) begin
                q_hit  = 1'b1;
                q_data = mem_data_q[bp_idx];
            end
        end
    end
`else
    logic unused_q_addr;

    assign q_hit         = 1'b0;
    assign q_data        = '0;
    assign unused_q_addr = ^q_addr;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
module tb_reg_writeback;
    localparam int WIDTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } item_t;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wb_stall;
    logic                    wen;
    logic [AW-1:0]           addrw;
    logic [WIDTH-1:0]        dinw;
    logic                    rsv_en;
    logic [AW-1:0]           rsv_addr;
    logic [NR-1:0]           busy;
    logic [$clog2(DEPTH):0]  level;
    logic [AW-1:0]           q_addr;
    logic                    q_hit;
    logic [WIDTH-1:0]        q_data;

    reg_writeback_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) alu_if ();
    reg_writeback_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) lsu_if ();

    reg_writeback #(.WIDTH(WIDTH), .ADDR_WIDTH(AW), .NR_REGS(NR), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .alu      (alu_if),
        .lsu      (lsu_if),
        .wb_stall (wb_stall),
        .wen      (wen),
        .addrw    (addrw),
        .dinw     (dinw),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .busy     (busy),
        .level    (level),
        .q_addr   (q_addr),
        .q_hit    (q_hit),
        .q_data   (q_data)
    );

    always #5 clk = ~clk;

    // Reference model: pending producer results, FIFO contents, scoreboard,
    // last granted source, and the log of commits in order.
    item_t       alu_pend[$];
    item_t       lsu_pend[$];
    item_t       fifo_m[$];
    item_t       commits[$];
    logic [NR-1:0] busy_m;
    bit          last_was_alu;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        alu_pend.delete();
        lsu_pend.delete();
        fifo_m.delete();
        commits.delete();
        busy_m       = '0;
        last_was_alu = 1'b1;
    endtask

    task automatic idle_inputs();
        alu_if.valid = 1'b0;
        alu_if.addr  = '0;
        alu_if.data  = '0;
        lsu_if.valid = 1'b0;
        lsu_if.addr  = '0;
        lsu_if.data  = '0;
        wb_stall     = 1'b0;
        rsv_en       = 1'b0;
        rsv_addr     = '0;
        q_addr       = '0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        reset_model();
        #1;
        chk("rst_wen", wen, 0);
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_addrw", addrw, 0);
        chk("rst_dinw", dinw, 0);
        chk("rst_q_data", q_data, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input bit stall, input bit rv, input logic [AW-1:0] ra,
                        input logic [AW-1:0] qa);
        item_t ah, lh, it;
        bit    av, lv, ga, gl, full_m, exp_wen, ehit;
        logic [WIDTH-1:0] edata;

        av = (alu_pend.size() != 0);
        lv = (lsu_pend.size() != 0);
        ah = av ? alu_pend[0] : '0;
        lh = lv ? lsu_pend[0] : '0;
        alu_if.valid = av;
        alu_if.addr  = ah.addr;
        alu_if.data  = ah.data;
        lsu_if.valid = lv;
        lsu_if.addr  = lh.addr;
        lsu_if.data  = lh.data;
        wb_stall     = stall;
        rsv_en       = rv;
        rsv_addr     = ra;
        q_addr       = qa;
        #1;

        if (av && lv) begin
            ga = !last_was_alu;
            gl = last_was_alu;
        end else begin
            ga = av;
            gl = lv;
        end
        full_m  = (fifo_m.size() == DEPTH);
        exp_wen = (fifo_m.size() != 0) && !stall;

        chk("alu_ready", alu_if.ready, ga && !full_m);
        chk("lsu_ready", lsu_if.ready, gl && !full_m);
        chk("wen", wen, exp_wen);
        chk("level", level, fifo_m.size());
        chk("busy", busy, busy_m);
        if (fifo_m.size() != 0) begin
            chk("addrw", addrw, fifo_m[0].addr);
            chk("dinw", dinw, fifo_m[0].data);
        end
        if (rv && ra != 0) begin
            chk("rsv_not_busy", busy[ra], 0);
        end

        ehit  = 1'b0;
        edata = '0;
`ifdef REG_WRITEBACK_BYPASS_EN
        foreach (fifo_m[i]) begin
            if (qa != 0 && fifo_m[i].addr == qa) begin
                ehit  = 1'b1;
                edata = fifo_m[i].data;
            end
        end
`endif
        chk("q_hit", q_hit, ehit);
        chk("q_data", q_data, edata);

        @(posedge clk);
        if (exp_wen) begin
            it = fifo_m.pop_front();
            busy_m[it.addr] = 1'b0;
            commits.push_back(it);
        end
        if (!full_m && (ga || gl)) begin
            it = ga ? alu_pend.pop_front() : lsu_pend.pop_front();
            last_was_alu = ga;
            if (it.addr != 0) fifo_m.push_back(it);
        end
        if (rv && ra != 0) busy_m[ra] = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        item_t it;
        bit    rv;
        logic [AW-1:0] ra, qa;

        rst = 1'b1;
        idle_inputs();
        reset_model();
        #1 rst = 1'b0;
        #2;
        chk("init_wen", wen, 0);
        chk("init_level", level, 0);
        chk("init_busy", busy, 0);
        chk("init_addrw", addrw, 0);
        chk("init_dinw", dinw, 0);
        chk("init_q_hit", q_hit, 0);
        chk("init_q_data", q_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Single ALU result, one-cycle latency to commit.
        alu_pend.push_back('{addr: 5'd5, data: 32'hDEADBEEF});
        step(0, 0, 0, 0);
        chk("lat_wen", wen, 1);
        chk("lat_addrw", addrw, 5);
        chk("lat_dinw", dinw, 32'hDEADBEEF);
        step(0, 0, 0, 0);
        chk("lat_level", level, 0);

        // Contention right after reset: LSU first, then alternate.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alu_pend.push_back('{addr: AW'(1 + i), data: 32'hAAAA0000 + i});
            lsu_pend.push_back('{addr: AW'(11 + i), data: 32'h55550000 + i});
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        chk("rr_c0", commits[0].data, 32'h55550000);
        chk("rr_c1", commits[1].data, 32'hAAAA0000);
        chk("rr_c2", commits[2].data, 32'h55550001);
        chk("rr_c3", commits[3].data, 32'hAAAA0001);
        chk("rr_count", commits.size(), 8);

        // Stalled drain fills the FIFO; release drains in order.
        commits.delete();
        for (int i = 0; i < 6; i++) alu_pend.push_back('{addr: AW'(8 + i), data: 32'hC0DE0000 + i});
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0);
        chk("full_level", level, 4);
        chk("full_ready", alu_if.ready, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
        chk("stall_count", commits.size(), 6);
        for (int i = 0; i < 6; i++) chk("stall_order", commits[i].data, 32'hC0DE0000 + i);

        // Reserve x7, then the write to x7 clears it on commit.
        step(0, 1, 7, 0);
        chk("rsv7_set", busy[7], 1);
        alu_pend.push_back('{addr: 5'd7, data: 32'h77});
        step(0, 0, 0, 0);
        chk("rsv7_pending", busy[7], 1);
        step(0, 0, 0, 0);
        chk("rsv7_clear", busy[7], 0);

        // Reserve and commit of x7 in the same cycle: reserve wins.
        alu_pend.push_back('{addr: 5'd7, data: 32'h78});
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 7, 0);
        chk("rsv_commit_same", busy[7], 1);

        // x0 destination: handshake only.
        alu_pend.push_back('{addr: 5'd0, data: 32'h1234});
        step(0, 0, 0, 0);
        chk("x0_level", level, 0);
        chk("x0_wen", wen, 0);
        chk("x0_busy7", busy[7], 1);
        step(0, 0, 0, 0);

        // Bypass lookup with two pending writes to x3, then async reset.
        alu_pend.push_back('{addr: 5'd3, data: 32'd1});
        alu_pend.push_back('{addr: 5'd3, data: 32'd2});
        step(1, 0, 0, 3);
        step(1, 1, 9, 3);
        step(1, 0, 0, 3);
`ifdef REG_WRITEBACK_BYPASS_EN
        chk("bp_hit3", q_hit, 1);
        chk("bp_data3", q_data, 2);
`else
        chk("bp_hit3", q_hit, 0);
        chk("bp_data3", q_data, 0);
`endif
        step(1, 0, 0, 0);
        chk("bp_hit0", q_hit, 0);
        wb_stall = 1'b0;
        #1;
        chk("mid_wen_before", wen, 1);
        rst = 1'b0;
        #1;
        chk("mid_wen", wen, 0);
        chk("mid_level", level, 0);
        chk("mid_busy", busy, 0);
        reset_model();
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            if (alu_pend.size() < 3 && $urandom_range(0, 1) == 1)
                alu_pend.push_back('{addr: AW'($urandom_range(0, 31)), data: $urandom});
            if (lsu_pend.size() < 3 && $urandom_range(0, 1) == 1)
                lsu_pend.push_back('{addr: AW'($urandom_range(0, 31)), data: $urandom});
            ra = AW'($urandom_range(1, 31));
            rv = ($urandom_range(0, 3) == 0) && !busy_m[ra];
            if (fifo_m.size() != 0 && $urandom_range(0, 1) == 1)
                qa = fifo_m[$urandom_range(0, fifo_m.size() - 1)].addr;
            else
                qa = AW'($urandom_range(0, 31));
            step($urandom_range(0, 3) == 0, rv, ra, qa);
        end
        for (int c = 0; c < 40; c++) step(0, 0, 0, 0);
        chk("drain_level", level, 0);
        chk("drain_pend", alu_pend.size() + lsu_pend.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
